// File: rtl/div8x4_pkg.sv
// Shared types and widths for the sequential restoring divider.
package div8x4_pkg;

  localparam int unsigned DefDividendW = 8;
  localparam int unsigned DefDivisorW  = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } div_state_t;

  // Counter must hold the values 0..w inclusive.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/div8x4_step.sv
// One restoring-division iteration: shift in a dividend bit, compare, conditionally subtract.
module div8x4_step
  import div8x4_pkg::*;
#(
  parameter int unsigned DIVISOR_W = DefDivisorW
) (
  input  logic [DIVISOR_W:0]   rem,
  input  logic                 in_bit,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W:0]   rem_next,
  output logic                 q_bit
);

  logic [DIVISOR_W:0] shifted;
  logic [DIVISOR_W:0] dv;

  always_comb begin
    shifted  = {rem[DIVISOR_W-1:0], in_bit};
    dv       = {1'b0, divisor};
    // rem[DIVISOR_W] is always 0 between steps; folding it in keeps the compare total.
    q_bit    = rem[DIVISOR_W] | (shifted >= dv);
    rem_next = q_bit ? (shifted - dv) : shifted;
  end

endmodule

// File: rtl/div8x4.sv
// Sequential restoring divider with start/done handshake; one quotient bit per clock.
module div8x4
  import div8x4_pkg::*;
#(
  parameter int unsigned DIVIDEND_W = DefDividendW,
  parameter int unsigned DIVISOR_W  = DefDivisorW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int unsigned CntW = cnt_width(DIVIDEND_W);
  localparam logic [CntW-1:0] LastCnt = CntW'(DIVIDEND_W - 1);

  div_state_t            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DIVISOR_W:0]    rem_q, rem_d;
  logic [DIVIDEND_W-1:0] qsh_q, qsh_d;
  logic [DIVISOR_W-1:0]  dvsr_q, dvsr_d;
  logic [DIVIDEND_W-1:0] quot_q, quot_d;
  logic [DIVISOR_W-1:0]  remo_q, remo_d;
  logic                  dbz_q, dbz_d;

  logic [DIVISOR_W:0] step_rem;
  logic               step_q;

  div8x4_step #(
    .DIVISOR_W (DIVISOR_W)
  ) u_step (
    .rem      (rem_q),
    .in_bit   (qsh_q[DIVIDEND_W-1]),
    .divisor  (dvsr_q),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    qsh_d   = qsh_q;
    dvsr_d  = dvsr_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          qsh_d  = dividend;
          dvsr_d = divisor;
          rem_d  = '0;
          cnt_d  = '0;
          if (divisor == '0) begin
            quot_d  = {DIVIDEND_W{1'b1}};
            remo_d  = dividend[DIVISOR_W-1:0];
            dbz_d   = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StRun;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        rem_d = step_rem;
        qsh_d = {qsh_q[DIVIDEND_W-2:0], step_q};
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          quot_d  = qsh_d;
          remo_d  = step_rem[DIVISOR_W-1:0];
          dbz_d   = 1'b0;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rem_q   <= '0;
      qsh_q   <= '0;
      dvsr_q  <= '0;
      quot_q  <= '0;
      remo_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      qsh_q   <= qsh_d;
      dvsr_q  <= dvsr_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == StRun);
  assign done        = (state_q == StDone);
  assign quotient    = quot_q;
  assign remainder   = remo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div8x4.sv
// Directed bench for div8x4: hand-computed quotients, latency, handshake and reset cases.
module tb_div8x4;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int n_checks;
  int n_errors;

  div8x4 dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one divide from IDLE and check latency, busy cycles, results and done drop.
  task automatic run_div(input logic [7:0] a, input logic [3:0] b, input logic [7:0] eq,
                         input logic [3:0] er, input logic edbz, input int elat);
    int cyc;
    int busy_cnt;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    cyc      = 0;
    busy_cnt = 0;
    while (!done && cyc < 20) begin
      busy_cnt += int'(busy);
      tick();
      cyc++;
    end
    check($sformatf("lat %0d/%0d", a, b), 16'(cyc), 16'(elat));
    check($sformatf("busy %0d/%0d", a, b), 16'(busy_cnt), 16'(elat));
    check($sformatf("quot %0d/%0d", a, b), 16'(quotient), 16'(eq));
    check($sformatf("rem %0d/%0d", a, b), 16'(remainder), 16'(er));
    check($sformatf("dbz %0d/%0d", a, b), 16'(div_by_zero), 16'(edbz));
    tick();
    check($sformatf("done drop %0d/%0d", a, b), 16'(done), 16'd0);
    check($sformatf("hold %0d/%0d", a, b), 16'(quotient), 16'(eq));
  endtask

  initial begin
    int cyc;
    int n_done;
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    tick();
    tick();
    rst = 1'b0;
    check("reset busy", 16'(busy), 16'd0);
    check("reset done", 16'(done), 16'd0);
    check("reset quot", 16'(quotient), 16'd0);
    check("reset rem", 16'(remainder), 16'd0);
    check("reset dbz", 16'(div_by_zero), 16'd0);

    run_div(8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 8);
    run_div(8'd255, 4'd15, 8'd17, 4'd0, 1'b0, 8);
    run_div(8'd255, 4'd1, 8'd255, 4'd0, 1'b0, 8);
    run_div(8'd9, 4'd0, 8'd255, 4'd9, 1'b1, 0);
    run_div(8'd0, 4'd5, 8'd0, 4'd0, 1'b0, 8);
    run_div(8'd3, 4'd9, 8'd0, 4'd3, 1'b0, 8);
    run_div(8'd225, 4'd15, 8'd15, 4'd0, 1'b0, 8);

    // start pulse with new operands mid-run must be ignored
    dividend = 8'd100;
    divisor  = 4'd3;
    start    = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 0;
    while (!done && cyc < 20) begin
      if (cyc == 4) begin
        start    = 1'b1;
        dividend = 8'd50;
        divisor  = 4'd5;
      end else begin
        start = 1'b0;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    check("ignore lat", 16'(cyc), 16'd8);
    check("ignore quot", 16'(quotient), 16'd33);
    check("ignore rem", 16'(remainder), 16'd1);
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_done += int'(done);
    end
    check("ignore no 2nd done", 16'(n_done), 16'd0);

    // reset at iteration 3 discards the operation
    dividend = 8'd200;
    divisor  = 4'd7;
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("midrst busy", 16'(busy), 16'd0);
    check("midrst done", 16'(done), 16'd0);
    check("midrst quot", 16'(quotient), 16'd0);
    check("midrst rem", 16'(remainder), 16'd0);
    check("midrst dbz", 16'(div_by_zero), 16'd0);
    rst    = 1'b0;
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_done += int'(done);
    end
    check("midrst no done", 16'(n_done), 16'd0);
    run_div(8'd12, 4'd4, 8'd3, 4'd0, 1'b0, 8);

    // back-to-back with start held high
    dividend = 8'd17;
    divisor  = 4'd4;
    start    = 1'b1;
    tick();
    cyc = 0;
    while (!done && cyc < 20) begin
      tick();
      cyc++;
    end
    check("b2b lat1", 16'(cyc), 16'd8);
    check("b2b quot1", 16'(quotient), 16'd4);
    check("b2b rem1", 16'(remainder), 16'd1);
    dividend = 8'd250;
    divisor  = 4'd6;
    tick();
    check("b2b done drop", 16'(done), 16'd0);
    check("b2b busy", 16'(busy), 16'd1);
    check("b2b hold quot", 16'(quotient), 16'd4);
    check("b2b hold rem", 16'(remainder), 16'd1);
    start = 1'b0;
    cyc   = 1;
    while (!done && cyc < 20) begin
      tick();
      cyc++;
    end
    check("b2b spacing", 16'(cyc), 16'd9);
    check("b2b quot2", 16'(quotient), 16'd41);
    check("b2b rem2", 16'(remainder), 16'd4);
    tick();
    check("b2b final drop", 16'(done), 16'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
